ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the Basys2 board. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the attached keyboard. It uses the PS/2 host-request sequence and checks the device acknowledge. It sits beside the existing PS/2 receive path on the same PS2C/PS2D pins, driving them open-drain through pull-low enables.

---
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender (open-drain pulls); bit update 3 clk after a device clock fall (+8 with PS2_TX_GLITCH_FILTER_EN).
// Accepts tx_valid only while tx_ready (IDLE); one tx_done or tx_err pulse per accepted byte.
module ps2_host_tx #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic       ps2c_pull_low,
   output logic       ps2d_pull_low
);

   // Counter covers the longest programmed wait, and at least 20 ms of CLK_HZ.
   localparam int CNT_MAX0 = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_MAX1 = (CNT_MAX0 > START_CYCLES) ? CNT_MAX0 : START_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX1 > CLK_HZ / 50) ? CNT_MAX1 : CLK_HZ / 50;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_RELEASE
   } state_t;

   state_t           r_state;
   logic [1:0]       r_c_sync;
   logic [1:0]       r_d_sync;
   logic             r_c_prev;
   logic [9:0]       r_shift;
   logic [3:0]       r_bit_cnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tx_ready;
   logic             r_tx_done;
   logic             r_tx_err;
   logic             r_ps2c_pull;
   logic             r_ps2d_pull;

   logic             w_c_line;
   logic             w_d_line;
   logic             w_fall;
   logic             w_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_sync <= 2'b11;
         r_d_sync <= 2'b11;
      end else begin
         r_c_sync <= {r_c_sync[0], PS2C};
         r_d_sync <= {r_d_sync[0], PS2D};
      end
   end

`ifdef PS2_TX_GLITCH_FILTER_EN
   logic       r_c_filt;
   logic [2:0] r_filt_cnt;

   // Output flips only once the synchronized clock has disagreed with it for 8 samples in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_filt   <= 1'b1;
         r_filt_cnt <= 3'd0;
      end else if (r_c_sync[1] == r_c_filt) begin
         r_filt_cnt <= 3'd0;
      end else if (r_filt_cnt == 3'd7) begin
         r_c_filt   <= r_c_sync[1];
         r_filt_cnt <= 3'd0;
      end else begin
         r_filt_cnt <= r_filt_cnt + 3'd1;
      end
   end

   assign w_c_line = r_c_filt;
`else
   assign w_c_line = r_c_sync[1];
`endif

   assign w_d_line  = r_d_sync[1];
   assign w_fall    = r_c_prev & ~w_c_line;
   assign w_timeout = (r_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_c_prev    <= 1'b1;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_cnt       <= '0;
         r_tx_ready  <= 1'b1;
         r_tx_done   <= 1'b0;
         r_tx_err    <= 1'b0;
         r_ps2c_pull <= 1'b0;
         r_ps2d_pull <= 1'b0;
      end else begin
         r_c_prev  <= w_c_line;
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_valid) begin
                  r_shift     <= {1'b1, ~^tx_data, tx_data};
                  r_cnt       <= '0;
                  r_ps2c_pull <= 1'b1;
                  r_tx_ready  <= 1'b0;
                  r_state     <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (r_cnt == INH_LAST) begin
                  r_cnt       <= '0;
                  r_ps2d_pull <= 1'b1;
                  r_state     <= S_START;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == START_LAST) begin
                  r_cnt       <= '0;
                  r_bit_cnt   <= '0;
                  r_ps2c_pull <= 1'b0;
                  r_state     <= S_SEND;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SEND, S_ACK, S_RELEASE: begin
               r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
               if (!w_fall && w_timeout) begin
                  r_ps2c_pull <= 1'b0;
                  r_ps2d_pull <= 1'b0;
                  r_tx_ready  <= 1'b1;
                  // In RELEASE the byte's result has already been reported.
                  r_tx_err    <= (r_state != S_RELEASE);
                  r_state     <= S_IDLE;
               end else if (r_state == S_SEND) begin
                  if (w_fall) begin
                     r_ps2d_pull <= ~r_shift[0];
                     r_shift     <= {1'b1, r_shift[9:1]};
                     r_bit_cnt   <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd9) begin
                        r_state <= S_ACK;
                     end
                  end
               end else if (r_state == S_ACK) begin
                  if (w_fall) begin
                     r_tx_done <= ~w_d_line;
                     r_tx_err  <= w_d_line;
                     r_state   <= S_RELEASE;
                  end
               end else begin
                  if (r_c_sync[1] && w_d_line) begin
                     r_tx_ready <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_ready      = r_tx_ready;
   assign tx_done       = r_tx_done;
   assign tx_err        = r_tx_err;
   assign ps2c_pull_low = r_ps2c_pull;
   assign ps2d_pull_low = r_ps2d_pull;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on wired-AND lines, result and bit scoreboards.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int STC  = 16;
   localparam int TO   = 400;
   localparam int HALF = 20;
`ifdef PS2_TX_GLITCH_FILTER_EN
   localparam int LAT  = 11;
   localparam int FILT = 1;
`else
   localparam int LAT  = 3;
   localparam int FILT = 0;
`endif

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_DONE = 2'b10;
   localparam logic [1:0] RES_ERR  = 2'b01;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2c_pull_low, ps2d_pull_low;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       PS2C, PS2D;

   assign PS2C = dev_clk & ~ps2c_pull_low;
   assign PS2D = dev_data & ~ps2d_pull_low;

   ps2_host_tx #(
      .CLK_HZ(50_000_000), .INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
      .PS2C(PS2C), .PS2D(PS2D),
      .ps2c_pull_low(ps2c_pull_low), .ps2d_pull_low(ps2d_pull_low)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] exp_res[$];
   logic       exp_bits[$];
   logic [9:0] obs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_done || tx_err) begin
         if (exp_res.size() == 0)
            check("res_unexpected", 32'({tx_done, tx_err}), 32'(RES_NONE));
         else
            check("res", 32'({tx_done, tx_err}), 32'(exp_res.pop_front()));
      end
   end

   // Accept a byte, measure the inhibit window, then clock out n_edges device clocks.
   task automatic xfer(input logic [7:0] data, input int n_edges, input bit ack,
                       input logic [1:0] res, input bit blocked);
      int   low;
      logic bitv;
      for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
      exp_bits.push_back(~^data);
      exp_bits.push_back(1'b1);
      if (res != RES_NONE) exp_res.push_back(res);
      obs = '0;
      @(negedge clk);
      tx_data  = data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~data;
      check("acc_pull", 32'(ps2c_pull_low), 32'd1);
      check("busy_ready", 32'(tx_ready), 32'd0);
      low = 0;
      while (ps2c_pull_low && low < INH + STC + 50) begin
         if (blocked && low == 10) begin
            tx_valid = 1'b1;
            check("blocked_ready", 32'(tx_ready), 32'd0);
         end else begin
            tx_valid = 1'b0;
         end
         low++;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check("clk_low", 32'(low), 32'(INH + STC));
      check("start_bit", 32'(ps2d_pull_low), 32'd1);
      repeat (5) @(negedge clk);
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 11 && ack) dev_data = 1'b0;
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (e <= 10) begin
            bitv       = PS2D;
            obs[e-1]   = bitv;
            if (exp_bits.size() > 0)
               check($sformatf("bit%0d", e), 32'(bitv), 32'(exp_bits.pop_front()));
         end
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         if (e == 11) dev_data = 1'b1;
      end
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!tx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(tx_ready), 32'd1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_bits.delete();
      exp_res.delete();
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_err", 32'(tx_err), 32'd0);
      check("rst_cpull", 32'(ps2c_pull_low), 32'd0);
      check("rst_dpull", 32'(ps2d_pull_low), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      xfer(8'hED, 11, 1'b1, RES_DONE, 1'b0);
      wait_ready("ed_ready");
      check("ed_line", 32'(obs), 32'h3ED);
      check("ed_pulls", 32'({ps2c_pull_low, ps2d_pull_low}), 32'd0);

      xfer(8'h00, 11, 1'b1, RES_DONE, 1'b0);
      wait_ready("b00_ready");
      check("par00", 32'(obs[8]), 32'd1);

      xfer(8'h01, 11, 1'b1, RES_DONE, 1'b0);
      wait_ready("b01_ready");
      check("par01", 32'(obs[8]), 32'd0);

      xfer(8'hF4, 11, 1'b0, RES_ERR, 1'b0);
      wait_ready("noack_ready");
      check("noack_pulls", 32'({ps2c_pull_low, ps2d_pull_low}), 32'd0);

      // Device goes silent after edge 4.
      xfer(8'h3C, 4, 1'b0, RES_ERR, 1'b0);
      k = 0;
      while (!tx_err && k < TO + 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("timeout_lat", 32'(k), 32'(TO + LAT - 2 * HALF));
      @(negedge clk);
      check("timeout_pulls", 32'({ps2c_pull_low, ps2d_pull_low}), 32'd0);
      check("timeout_ready", 32'(tx_ready), 32'd1);
      exp_bits.delete();

      // Bit 5 of 0x5C is 0, so data is pulled low when reset hits.
      xfer(8'h5C, 6, 1'b0, RES_NONE, 1'b1);
      check("bit5_drive", 32'(ps2d_pull_low), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_pulls", 32'({ps2c_pull_low, ps2d_pull_low}), 32'd0);
      check("arst_ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_bits.delete();
      exp_res.delete();
      @(negedge clk);
      check("post_rst_ready", 32'(tx_ready), 32'd1);

      // 3-cycle clock glitch while bit 2 (1) of 0x55 is presented; bit 3 is 0.
      xfer(8'h55, 3, 1'b0, RES_NONE, 1'b0);
      check("pre_glitch", 32'(ps2d_pull_low), 32'd0);
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (15) @(negedge clk);
      check("glitch", 32'(ps2d_pull_low), 32'(FILT == 1 ? 0 : 1));
      pulse_reset();

      repeat (20) @(negedge clk);
      check("res_left", 32'(exp_res.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
